// File: rtl/hud_state_if.sv
// hud_state_if -- event pulses into the HUD tracker and the frame-stable
// display values coming back out.
//
// Signals
//   gem_collect   one-cycle pulse: add one to the score
//   player_hit    one-cycle pulse: the player took damage
//   heart_pickup  one-cycle pulse: restore one health
//   game_restart  one-cycle pulse: start a new game
//   score1        displayed score, ones digit (BCD 0-9)
//   score2        displayed score, tens digit (BCD 0-9)
//   health        displayed health (0-3)
//   game_over     high while the game is over
//   blink         high on invulnerability frames where the sprite is hidden
//
// Modports
//   master  game logic side: drives the pulses, reads the display values
//   slave   hud_state side: takes the pulses, drives the display values
interface hud_state_if;
  logic       gem_collect;
  logic       player_hit;
  logic       heart_pickup;
  logic       game_restart;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] health;
  logic       game_over;
  logic       blink;

  modport master (
    output gem_collect,
    output player_hit,
    output heart_pickup,
    output game_restart,
    input  score1,
    input  score2,
    input  health,
    input  game_over,
    input  blink
  );

  modport slave (
    input  gem_collect,
    input  player_hit,
    input  heart_pickup,
    input  game_restart,
    output score1,
    output score2,
    output health,
    output game_over,
    output blink
  );
endinterface

// File: rtl/hud_state.sv
// hud_state -- score / health / invulnerability tracker for the game HUD.
//
// Event pulses update a set of working registers (BCD score, health, player
// FSM, invulnerability frame counter) on the cycle they are sampled. The
// values the display sees are shadow copies that reload only on the cycle
// after a vertical-sync rising edge, so nothing visible changes mid-frame.
//
// Ports
//   Clk        system clock, all state changes on its rising edge
//   Reset_n    asynchronous active-low reset
//   frame_clk  VGA vertical-sync level, asynchronous to Clk
//   hud        hud_state_if.slave: event pulses in, display values out
//
// Parameters
//   INVULN_FRAMES  frame edges of invulnerability after an accepted hit
module hud_state #(
  parameter int INVULN_FRAMES = 60
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  hud_state_if.slave  hud
);

  // The counter must hold INVULN_FRAMES and always have a bit 2 for blink.
  localparam int CW_RAW = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);
  localparam int CW     = (CW_RAW < 3) ? 3 : CW_RAW;
  localparam logic [CW-1:0] INVULN_LOAD = CW'(INVULN_FRAMES);

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  // ------------------------------------------------------------------
  // frame_clk synchronizer and rising-edge detector
  // ------------------------------------------------------------------
  logic       sync1_reg;
  logic       sync2_reg;
  logic       sync_prev_reg;
  logic [1:0] sync_vld_reg;
  logic       armed_reg;
  logic       load_reg;
  logic       frame_edge;

  // sync_vld_reg marks when sync2_reg carries a real sample of frame_clk
  // rather than its reset value. The detector only arms after a real low
  // has been seen, so a frame_clk already high at reset release does not
  // count as a rising edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      sync_prev_reg <= 1'b0;
      sync_vld_reg  <= 2'b00;
      armed_reg     <= 1'b0;
      load_reg      <= 1'b0;
    end else begin
      sync1_reg     <= frame_clk;
      sync2_reg     <= sync1_reg;
      sync_prev_reg <= sync2_reg;
      sync_vld_reg  <= {sync_vld_reg[0], 1'b1};
      armed_reg     <= armed_reg | (sync_vld_reg[1] & ~sync2_reg);
      load_reg      <= frame_edge;
    end
  end

  assign frame_edge = sync2_reg & ~sync_prev_reg & armed_reg;

  // ------------------------------------------------------------------
  // Working state
  // ------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [3:0]    ones_reg,  ones_next;
  logic [3:0]    tens_reg,  tens_next;
  logic [1:0]    hp_reg,    hp_next;
  logic [CW-1:0] cnt_reg,   cnt_next;
  logic [1:0]    hp_heart;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= ALIVE;
      ones_reg  <= 4'd0;
      tens_reg  <= 4'd0;
      hp_reg    <= 2'd3;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ones_reg  <= ones_next;
      tens_reg  <= tens_next;
      hp_reg    <= hp_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ones_next  = ones_reg;
    tens_next  = tens_reg;
    hp_next    = hp_reg;
    cnt_next   = cnt_reg;

    // Health after a saturating heart; an accepted hit is applied on top
    // of this so that both pulses together behave as heart-then-hit.
    hp_heart = hp_reg;
    if (hud.heart_pickup && (hp_reg != 2'd3)) begin
      hp_heart = hp_reg + 2'd1;
    end

    if (hud.game_restart) begin
      state_next = ALIVE;
      ones_next  = 4'd0;
      tens_next  = 4'd0;
      hp_next    = 2'd3;
      cnt_next   = '0;
    end else begin
      // BCD score, saturating at 99.
      if (hud.gem_collect && (state_reg != GAME_OVER)) begin
        if (ones_reg == 4'd9) begin
          if (tens_reg != 4'd9) begin
            ones_next = 4'd0;
            tens_next = tens_reg + 4'd1;
          end
        end else begin
          ones_next = ones_reg + 4'd1;
        end
      end

      case (state_reg)
        ALIVE: begin
          hp_next = hp_heart;
          if (hud.player_hit) begin
            if (hp_heart > 2'd1) begin
              hp_next    = hp_heart - 2'd1;
              cnt_next   = INVULN_LOAD;
              state_next = INVULN;
            end else begin
              hp_next    = 2'd0;
              state_next = GAME_OVER;
            end
          end
        end

        INVULN: begin
          // Hits are ignored here; hearts still count.
          hp_next = hp_heart;
          if (frame_edge) begin
            if (cnt_reg <= CW'(1)) begin
              cnt_next   = '0;
              state_next = ALIVE;
            end else begin
              cnt_next = cnt_reg - CW'(1);
            end
          end
        end

        GAME_OVER: begin
          // Only a restart leaves this state.
        end

        default: begin
          state_next = ALIVE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Display shadows, reloaded once per frame
  // ------------------------------------------------------------------
  logic [3:0] score1_reg;
  logic [3:0] score2_reg;
  logic [1:0] health_reg;
  logic       game_over_reg;
  logic       blink_reg;
  logic       blink_work;

  assign blink_work = (state_reg == INVULN) & cnt_reg[2];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score1_reg    <= 4'd0;
      score2_reg    <= 4'd0;
      health_reg    <= 2'd3;
      game_over_reg <= 1'b0;
      blink_reg     <= 1'b0;
    end else if (load_reg) begin
      score1_reg    <= ones_reg;
      score2_reg    <= tens_reg;
      health_reg    <= hp_reg;
      game_over_reg <= (state_reg == GAME_OVER);
      blink_reg     <= blink_work;
    end
  end

  assign hud.score1    = score1_reg;
  assign hud.score2    = score2_reg;
  assign hud.health    = health_reg;
  assign hud.game_over = game_over_reg;
  assign hud.blink     = blink_reg;

endmodule

// File: doc/hud_state.md
HUD_STATE -- requirements
Module: hud_state

Interface
REQ-001 Parameter INVULN_FRAMES, default 60: number of frame edges the player stays invulnerable after an accepted hit.
REQ-002 Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 frame_clk  input  1  VGA vertical-sync level; asynchronous to Clk.
REQ-005 gem_collect  input  1  one-cycle pulse: add one to the score.
REQ-006 player_hit  input  1  one-cycle pulse: the player took damage.
REQ-007 heart_pickup  input  1  one-cycle pulse: restore one health.
REQ-008 game_restart  input  1  one-cycle pulse: start a new game.
REQ-009 score1  output  4  displayed score, ones digit, BCD 0-9.
REQ-010 score2  output  4  displayed score, tens digit, BCD 0-9.
REQ-011 health  output  2  displayed health, 0-3.
REQ-012 game_over  output  1  high while the FSM is in GAME_OVER.
REQ-013 blink  output  1  high during invulnerability frames in which the player sprite is hidden.

Function
REQ-014 frame_clk shall pass through a 2-flop synchronizer; frame_edge shall be a one-cycle pulse on the synchronized 0->1 transition.
REQ-015 Working registers ones, tens and hp shall update on the cycle an event pulse is sampled.
REQ-016 score1, score2 and health shall be shadow copies of ones, tens and hp.
REQ-017 The shadow copies shall load only on the cycle after frame_edge, so the displayed values never change mid-frame.
REQ-018 game_over shall follow the same shadow timing as score1, score2 and health.
REQ-019 gem_collect: ones+1; ones 9 -> 0 with tens+1.
REQ-020 gem_collect at tens=9, ones=9 shall saturate the score at 99.
REQ-021 The FSM shall have three states: ALIVE, INVULN, GAME_OVER.
REQ-022 ALIVE: player_hit with hp>1 -> hp-1, invulnerability counter = INVULN_FRAMES, go to INVULN.
REQ-023 ALIVE: player_hit with hp=1 -> hp=0, go to GAME_OVER.
REQ-024 INVULN: player_hit shall be ignored.
REQ-025 INVULN: the counter shall decrement on each frame_edge; on the frame_edge where it reaches 0, the FSM shall return to ALIVE.
REQ-026 heart_pickup in ALIVE or INVULN: hp+1, saturating at 3.
REQ-027 heart_pickup and an accepted player_hit in the same cycle: apply the saturating heart first, then the hit.
REQ-028 Example for REQ-027: hp=3 with both pulses -> hp=2, INVULN; hp=1 with both pulses -> hp=1, INVULN.
REQ-029 GAME_OVER: gem_collect, player_hit and heart_pickup shall be ignored.
REQ-030 game_restart in any state: ones=0, tens=0, hp=3, counter cleared, FSM -> ALIVE.
REQ-031 game_restart shall take priority over every other pulse sampled in the same cycle.
REQ-032 blink = counter bit 2 while in INVULN; blink = 0 otherwise.
REQ-033 blink shall be shadowed with the other outputs.
REQ-034 Worst-case latency from an event pulse to a visible output shall be one frame period plus 4 Clk cycles.

Reset
REQ-035 Reset_n low shall immediately set: score1=0, score2=0, health=3, game_over=0, blink=0.
REQ-036 Reset_n low shall also clear ones, tens, the invulnerability counter and the synchronizer flops, set hp=3, and set the FSM to ALIVE.
REQ-037 Reset asserted mid-frame or during INVULN shall discard all pending working state.
REQ-038 After release, no frame_edge shall be generated if frame_clk is already high.
REQ-039 Outputs shall first reload on the next genuine 0->1 transition of frame_clk.

Verification
REQ-040 Score and shadow timing: 12 gem pulses within one frame, then one frame_edge -> score2=1, score1=2; outputs unchanged before the edge.
REQ-041 Score saturation: 105 gem pulses -> after the next frame_edge, score2=9, score1=9.
REQ-042 Hit and invulnerability: hit at hp=3 -> health=2; a second hit 10 frames later is ignored; after 60 frame edges a third hit -> health=1.
REQ-043 Game over: hits at hp=1, plus a gem and a heart afterwards -> health=0, game_over=1, score unchanged, health remains 0.
REQ-044 Simultaneous events: at hp=3, heart_pickup and player_hit in the same cycle -> health=2, blink toggles every 4 frames.
REQ-045 Restart and reset: game_restart together with gem_collect in GAME_OVER -> score 00, health=3, game_over=0; Reset_n pulsed mid-INVULN -> outputs immediately 00/3/0/0.
